// File: rtl/fifo_pixel_unpacker_pkg.sv
// Shared types and elaboration helpers for the FWFT pixel unpacker.
package fifo_pixel_unpacker_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Bits needed to index n items; never less than 1 so degenerate sizes still elaborate.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_pixel_unpacker.sv
// Pops wide words from a first-word-fall-through FIFO and streams them out as pixels,
// LSB first, tagging start/end of line and counting completed lines.
module fifo_pixel_unpacker
    import fifo_pixel_unpacker_pkg::*;
#(
    parameter int DELAY     = 1,
    parameter int IN_WIDTH  = 256,
    parameter int PIX_WIDTH = 16,
    parameter int LINE_PIX  = 2048,
    parameter int LCNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_rden,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [PIX_WIDTH-1:0] pix_data,
    output logic                 pix_sol,
    output logic                 pix_eol,
    output logic [LCNT_W-1:0]    line_count
);

    localparam int N_PIX  = IN_WIDTH / PIX_WIDTH;
    localparam int PIDX_W = log2(N_PIX);
    localparam int CCNT_W = log2(LINE_PIX);
    localparam logic [PIDX_W-1:0] PIDX_MAX = PIDX_W'(N_PIX - 1);
    localparam logic [CCNT_W-1:0] CCNT_MAX = CCNT_W'(LINE_PIX - 1);

    // A word must never straddle two lines, otherwise sol/eol tagging breaks.
    if ((IN_WIDTH % PIX_WIDTH) != 0 || (LINE_PIX % N_PIX) != 0 || DELAY < 0) begin : g_param_err
        $error("fifo_pixel_unpacker: bad parameters (IN_WIDTH/PIX_WIDTH/LINE_PIX)");
    end

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q,  word_d;
    logic [PIDX_W-1:0]     pidx_q,  pidx_d;
    logic                  vld_q,   vld_d;
    logic [CCNT_W-1:0]     ccnt_q,  ccnt_d;
    logic [LCNT_W-1:0]     lcnt_q,  lcnt_d;
    logic                  xfer, last, load;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pidx_d  = pidx_q;
        vld_d   = vld_q;
        ccnt_d  = ccnt_q;
        lcnt_d  = lcnt_q;
        xfer    = vld_q && pix_ready;
        last    = xfer && (pidx_q == PIDX_MAX);
        // Gated by RESET so a word is never popped while it would be thrown away.
        load    = !RESET && !fifo_empty && (state_q == ST_EMPTY || last);

        if (xfer) begin
            ccnt_d = (ccnt_q == CCNT_MAX) ? '0 : ccnt_q + 1'b1;
            if (ccnt_q == CCNT_MAX) lcnt_d = lcnt_q + 1'b1;
            if (!last) begin
                pidx_d = pidx_q + 1'b1;
                word_d = word_q >> PIX_WIDTH;
            end else begin
                state_d = ST_EMPTY;
                vld_d   = 1'b0;
            end
        end

        // Reload on the last transfer overrides the drain, giving zero-bubble streaming.
        if (load) begin
            word_d  = fifo_dout;
            pidx_d  = '0;
            state_d = ST_HOLD;
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            pidx_q  <= '0;
            vld_q   <= 1'b0;
            ccnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pidx_q  <= pidx_d;
            vld_q   <= vld_d;
            ccnt_q  <= ccnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign fifo_rden  = load;
    assign pix_valid  = vld_q;
    assign pix_data   = word_q[PIX_WIDTH-1:0];
    assign pix_sol    = vld_q && (ccnt_q == '0);
    assign pix_eol    = vld_q && (ccnt_q == CCNT_MAX);
    assign line_count = lcnt_q;

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Scoreboard bench: a FWFT FIFO model feeds the unpacker, expected pixels are queued on push.
module tb_fifo_pixel_unpacker;

    localparam int IW = 256;
    localparam int PW = 16;
    localparam int NP = IW / PW;
    localparam int LP = 32;
    localparam int LW = 2;

    typedef struct {
        logic [PW-1:0] d;
        logic          sol;
        logic          eol;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [IW-1:0] fifo_dout = '0;
    logic          fifo_rden;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [PW-1:0] pix_data;
    logic          pix_sol, pix_eol;
    logic [LW-1:0] line_count;

    fifo_pixel_unpacker #(
        .DELAY(1), .IN_WIDTH(IW), .PIX_WIDTH(PW), .LINE_PIX(LP), .LCNT_W(LW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rden(fifo_rden), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sol(pix_sol), .pix_eol(pix_eol), .line_count(line_count)
    );

    always #5 CLK = ~CLK;

    logic [IW-1:0] fq[$];
    exp_t          sbq[$];
    logic [LW-1:0] lc_log[$];
    int            nvec = 0, nerr = 0;
    int            mccnt = 0, mpidx = 0;
    logic [LW-1:0] exp_lc = '0;
    bit            prev_stall = 0, lc_pend = 0;
    logic [PW-1:0] prev_d;
    logic          prev_sol, prev_eol;

    // FWFT FIFO model: pops on a sampled rden, updates its outputs shortly after the edge.
    always @(posedge CLK) begin : fifo_model
        bit p;
        p = fifo_rden;
        #2;
        if (p && fq.size() > 0) void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET) begin
            if (lc_pend) lc_log.push_back(line_count);
            lc_pend = 0;
            nvec++;
            if (line_count !== exp_lc) begin
                nerr++; $display("FAIL line_count: got %0d want %0d", line_count, exp_lc);
            end
            if (fifo_rden && fifo_empty) begin
                nerr++; $display("FAIL rden_when_empty: rden=1 empty=1");
            end
            if (fifo_rden && pix_valid) begin
                nvec++;
                if (!(pix_ready && mpidx == NP - 1)) begin
                    nerr++; $display("FAIL rden_mid_word: got pop at pidx %0d ready %0b, want pidx %0d ready 1",
                                     mpidx, pix_ready, NP - 1);
                end
            end
            if (prev_stall) begin
                nvec++;
                if (pix_valid !== 1'b1 || pix_data !== prev_d || pix_sol !== prev_sol || pix_eol !== prev_eol) begin
                    nerr++; $display("FAIL stall_hold: got v%0b %h s%0b e%0b want v1 %h s%0b e%0b",
                                     pix_valid, pix_data, pix_sol, pix_eol, prev_d, prev_sol, prev_eol);
                end
            end
            if (pix_valid && pix_ready) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL unexpected_pixel: got %h want none", pix_data);
                end else begin
                    e = sbq.pop_front();
                    if (pix_data !== e.d || pix_sol !== e.sol || pix_eol !== e.eol) begin
                        nerr++; $display("FAIL pixel: got %h s%0b e%0b want %h s%0b e%0b",
                                         pix_data, pix_sol, pix_eol, e.d, e.sol, e.eol);
                    end
                    if (e.eol) begin
                        exp_lc  = exp_lc + 1'b1;
                        lc_pend = 1;
                    end
                end
                mpidx = (mpidx + 1) % NP;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_d     = pix_data;
            prev_sol   = pix_sol;
            prev_eol   = pix_eol;
        end
    end

    task automatic push_word(input logic [IW-1:0] w);
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            e.d   = w[i*PW +: PW];
            e.sol = (mccnt == 0);
            e.eol = (mccnt == LP - 1);
            mccnt = (mccnt + 1) % LP;
            sbq.push_back(e);
        end
        fq.push_back(w);
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        sbq.delete();
        lc_log.delete();
        mccnt = 0; mpidx = 0; exp_lc = '0;
        prev_stall = 0; lc_pend = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || fq.size() != 0 || pix_valid) && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        nvec++;
        if (n >= budget) begin
            nerr++; $display("FAIL %s_timeout: got %0d pixels pending want 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        pix_ready = 1'b1;
        apply_reset();
        @(negedge CLK);
        nvec++;
        if (pix_valid !== 1'b0 || line_count !== '0 || fifo_rden !== 1'b0 || pix_sol !== 1'b0 || pix_data !== '0) begin
            nerr++; $display("FAIL reset_state: got v%0b lc%0d rden%0b sol%0b d%h want all 0",
                             pix_valid, line_count, fifo_rden, pix_sol, pix_data);
        end
    endtask

    task automatic test_single();
        logic [IW-1:0] w;
        for (int i = 0; i < NP; i++) w[i*PW +: PW] = PW'(i + 1);
        pix_ready = 1'b1;
        @(posedge CLK); #1;
        push_word(w);
        @(negedge CLK);
        nvec++;
        if (fifo_rden !== 1'b1 || pix_valid !== 1'b0) begin
            nerr++; $display("FAIL single_pop: got rden%0b v%0b want rden1 v0", fifo_rden, pix_valid);
        end
        @(negedge CLK);
        nvec++;
        if (pix_valid !== 1'b1 || fifo_rden !== 1'b0 || pix_data !== 16'h0001) begin
            nerr++; $display("FAIL single_latency: got v%0b rden%0b d%h want v1 rden0 d0001",
                             pix_valid, fifo_rden, pix_data);
        end
        repeat (15) @(negedge CLK);
        @(negedge CLK);
        nvec++;
        if (pix_valid !== 1'b0) begin
            nerr++; $display("FAIL single_drain: got v%0b want v0", pix_valid);
        end
        wait_drain(50, "single");
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] w;
        int rd;
        pix_ready = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NP; i++) w[i*PW +: PW] = {8'(8'hB0 + k), 8'(i)};
            push_word(w);
        end
        @(negedge CLK);
        rd = 0;
        for (int c = 0; c < 4 * NP; c++) begin
            @(negedge CLK);
            nvec++;
            if (pix_valid !== 1'b1) begin
                nerr++; $display("FAIL b2b_bubble: got v0 at pixel %0d want v1", c);
            end
            if (fifo_rden) rd++;
        end
        nvec++;
        if (rd != 3) begin
            nerr++; $display("FAIL b2b_reloads: got %0d pops want 3", rd);
        end
        wait_drain(50, "b2b");
    endtask

    task automatic test_random_stall();
        logic [IW-1:0] w;
        int n;
        @(posedge CLK); #1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NP; i++) w[i*PW +: PW] = PW'($urandom);
            push_word(w);
        end
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(posedge CLK); #1;
            pix_ready = 1'($urandom_range(0, 1));
            n++;
        end
        pix_ready = 1'b1;
        wait_drain(100, "random");
    endtask

    task automatic test_lines();
        logic [IW-1:0] w;
        logic [LW-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pix_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NP; i++) w[i*PW +: PW] = PW'(k * NP + i);
            push_word(w);
        end
        wait_drain(400, "lines");
        @(negedge CLK);
        nvec++;
        if (lc_log.size() != 5) begin
            nerr++; $display("FAIL lines_count: got %0d eol lines want 5", lc_log.size());
        end
        for (int i = 0; i < 5 && i < lc_log.size(); i++) begin
            nvec++;
            if (lc_log[i] !== want[i]) begin
                nerr++; $display("FAIL lines_seq[%0d]: got %0d want %0d", i, lc_log[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [IW-1:0] w;
        int n;
        pix_ready = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < NP; i++) w[i*PW +: PW] = PW'(16'h5000 + i);
        push_word(w);
        n = 0;
        do begin
            @(negedge CLK); #1;
            n++;
        end while (!(pix_valid && mpidx == 7) && n < 100);
        RESET = 1'b1;
        sbq.delete(); lc_log.delete();
        mccnt = 0; mpidx = 0; exp_lc = '0; prev_stall = 0; lc_pend = 0;
        #1;
        nvec++;
        if (pix_valid !== 1'b0 || line_count !== '0 || n >= 100) begin
            nerr++; $display("FAIL midreset_clear: got v%0b lc%0d waited %0d want v0 lc0", pix_valid, line_count, n);
        end
        @(posedge CLK); #1 RESET = 1'b0;
        for (int i = 0; i < NP; i++) w[i*PW +: PW] = 16'hAAAA;
        push_word(w);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!pix_valid && n < 20);
        nvec++;
        if (pix_data !== 16'hAAAA || pix_sol !== 1'b1 || line_count !== '0) begin
            nerr++; $display("FAIL midreset_first: got d%h sol%0b lc%0d want dAAAA sol1 lc0",
                             pix_data, pix_sol, line_count);
        end
        wait_drain(50, "midreset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stall();
        test_lines();
        test_reset_midword();
        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
